// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the sequential FPU arithmetic units.
//   - fp_state_t      : control states of the multi-cycle add/sub sequencer
//   - RM_*            : rounding-mode encodings carried on rnd_mode[1:0]
//   - FLAG_*          : bit positions of the exception flags in a flag vector
//   - canonical_qnan, is_nan, is_snan, is_inf : classification helpers that
//     work on any format up to FP_MAX_W bits.  The operand is passed
//     zero-extended to FP_MAX_W, together with its exponent and fraction widths.
// ---------------------------------------------------------------------------
package fpu_pkg;

   localparam int FP_MAX_W = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } fp_state_t;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   localparam int FLAG_ZERO      = 0;
   localparam int FLAG_INEXACT   = 1;
   localparam int FLAG_UNDERFLOW = 2;
   localparam int FLAG_OVERFLOW  = 3;
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_COUNT     = 5;

   // Biased exponent field, right-justified
   function automatic logic [FP_MAX_W-1:0] exp_field(input logic [FP_MAX_W-1:0] x,
                                                      input int exp_w, input int frac_w);
      return (x >> frac_w) & ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1));
   endfunction

   // Stored fraction field
   function automatic logic [FP_MAX_W-1:0] frac_field(input logic [FP_MAX_W-1:0] x,
                                                       input int frac_w);
      return x & ((FP_MAX_W'(1) << frac_w) - FP_MAX_W'(1));
   endfunction

   // Positive quiet NaN with only the fraction MSB set
   function automatic logic [FP_MAX_W-1:0] canonical_qnan(input int exp_w, input int frac_w);
      return (((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << frac_w) |
             (FP_MAX_W'(1) << (frac_w - 1));
   endfunction

   function automatic logic is_nan(input logic [FP_MAX_W-1:0] x,
                                   input int exp_w, input int frac_w);
      return (exp_field(x, exp_w, frac_w) == ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1))) &&
             (frac_field(x, frac_w) != '0);
   endfunction

   // Signalling NaN: a NaN whose fraction MSB is clear
   function automatic logic is_snan(input logic [FP_MAX_W-1:0] x,
                                    input int exp_w, input int frac_w);
      return is_nan(x, exp_w, frac_w) &&
             (((x >> (frac_w - 1)) & FP_MAX_W'(1)) == '0);
   endfunction

   function automatic logic is_inf(input logic [FP_MAX_W-1:0] x,
                                   input int exp_w, input int frac_w);
      return (exp_field(x, exp_w, frac_w) == ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1))) &&
             (frac_field(x, frac_w) == '0);
   endfunction

endpackage

// File: rtl/fp_round_incr.sv
// ---------------------------------------------------------------------------
// fp_round_incr
// Combinational rounding decision shared by the FPU arithmetic units.
// Ports:
//   lsb, g, r, s : last kept mantissa bit and guard/round/sticky bits
//   sign         : sign of the value being rounded
//   rnd_mode     : RM_RNE / RM_RTZ / RM_RUP / RM_RDN
//   increment    : add one ulp to the kept mantissa
//   inexact      : discarded bits were nonzero
// ---------------------------------------------------------------------------
module fp_round_incr
   import fpu_pkg::*;
(
   input  logic       lsb,
   input  logic       g,
   input  logic       r,
   input  logic       s,
   input  logic       sign,
   input  logic [1:0] rnd_mode,
   output logic       increment,
   output logic       inexact
);

   // Directed modes only bump the magnitude when rounding away from zero
   // moves toward their infinity; RNE breaks an exact tie using the LSB.
   always_comb begin
      inexact   = g | r | s;
      increment = 1'b0;
      case (rnd_mode)
         RM_RNE:  increment = g & (r | s | lsb);
         RM_RTZ:  increment = 1'b0;
         RM_RUP:  increment = ~sign & (g | r | s);
         RM_RDN:  increment = sign & (g | r | s);
         default: increment = 1'b0;
      endcase
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// fp_addsub_seq
// Multi-cycle IEEE 754 add/subtract with denormals, four rounding modes and
// five exception flags.  One operation in flight; valid/ready on both sides.
// Ports:
//   clk_in, rst         : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only when idle)
//   opa, opb            : packed operands
//   op_sub              : 1 = A-B, 0 = A+B
//   rnd_mode            : 00 RNE, 01 RTZ, 10 RUP, 11 RDN
//   out_valid/out_ready : result handshake; result and flags held until taken
//   result              : packed result
//   invalid, overflow, underflow, inexact, zero : exception/status flags
// ---------------------------------------------------------------------------
module fp_addsub_seq
   import fpu_pkg::*;
#(
   parameter  int EXP_W  = 8,
   parameter  int FRAC_W = 23,
   localparam int W      = EXP_W + FRAC_W + 1
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   input  logic         op_sub,
   input  logic [1:0]   rnd_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         invalid,
   output logic         overflow,
   output logic         underflow,
   output logic         inexact,
   output logic         zero
);

   // Mantissa layout: carry, hidden, fraction, G, R, S
   localparam int MW    = FRAC_W + 5;
   localparam int SHMAX = FRAC_W + 3;
   localparam logic [EXP_W:0] EXP_ONE = (EXP_W + 1)'(1);

   fp_state_t             state;
   logic [W-1:0]          a_r, b_r;
   logic [1:0]            rnd_r;
   logic [MW-1:0]         ma_r, mb_r, m_r;
   logic [EXP_W:0]        exp_r;
   logic                  sign_r, eff_sub_r;
   logic [W-1:0]          result_r;
   logic [FLAG_COUNT-1:0] flags_r;
   logic                  out_valid_r;

   logic                  swap, big_sign;
   logic [EXP_W-1:0]      big_exp, small_exp, big_exp_eff, small_exp_eff;
   logic [EXP_W-1:0]      exp_diff, shift_amt;
   logic [FRAC_W-1:0]     big_frac, small_frac;
   logic [MW-1:0]         big_mant, small_mant, small_aligned;
   logic [2*MW-1:0]       shift_wide;

   logic                  a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic [W-1:0]          qnan_val;
   logic                  zero_sign;

   logic [MW-1:0]         add_sum;

   logic                  rnd_incr, rnd_inexact;
   logic [FRAC_W+1:0]     rnd_sum;
   logic                  fin_hidden, fin_ovf, to_inf;
   logic [FRAC_W-1:0]     fin_frac;
   logic [EXP_W:0]        fin_exp;
   logic [W-1:0]          rnd_result;
   logic [FLAG_COUNT-1:0] rnd_flags;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign invalid   = flags_r[FLAG_INVALID];
   assign overflow  = flags_r[FLAG_OVERFLOW];
   assign underflow = flags_r[FLAG_UNDERFLOW];
   assign inexact   = flags_r[FLAG_INEXACT];
   assign zero      = flags_r[FLAG_ZERO];

   // Special-operand classification of the captured operands.  B already
   // carries the effective sign, so A-B is handled as A+(-B) throughout.
   assign a_nan     = is_nan(FP_MAX_W'(a_r), EXP_W, FRAC_W);
   assign b_nan     = is_nan(FP_MAX_W'(b_r), EXP_W, FRAC_W);
   assign a_snan    = is_snan(FP_MAX_W'(a_r), EXP_W, FRAC_W);
   assign b_snan    = is_snan(FP_MAX_W'(b_r), EXP_W, FRAC_W);
   assign a_inf     = is_inf(FP_MAX_W'(a_r), EXP_W, FRAC_W);
   assign b_inf     = is_inf(FP_MAX_W'(b_r), EXP_W, FRAC_W);
   assign a_zero    = (a_r[W-2:0] == '0);
   assign b_zero    = (b_r[W-2:0] == '0);
   assign qnan_val  = W'(canonical_qnan(EXP_W, FRAC_W));
   assign zero_sign = (a_r[W-1] == b_r[W-1]) ? a_r[W-1] : (rnd_r == RM_RDN);

   // Alignment: the exponent/fraction bits compare as an unsigned magnitude,
   // so the larger operand is found without unpacking.  Denormals use
   // effective exponent 1 with a zero hidden bit.  The smaller mantissa is
   // shifted through a double-width window whose low half collapses into S.
   always_comb begin
      swap          = b_r[W-2:0] > a_r[W-2:0];
      big_sign      = swap ? b_r[W-1] : a_r[W-1];
      big_exp       = swap ? b_r[W-2:FRAC_W] : a_r[W-2:FRAC_W];
      small_exp     = swap ? a_r[W-2:FRAC_W] : b_r[W-2:FRAC_W];
      big_frac      = swap ? b_r[FRAC_W-1:0] : a_r[FRAC_W-1:0];
      small_frac    = swap ? a_r[FRAC_W-1:0] : b_r[FRAC_W-1:0];
      big_exp_eff   = (big_exp == '0) ? EXP_W'(1) : big_exp;
      small_exp_eff = (small_exp == '0) ? EXP_W'(1) : small_exp;
      big_mant      = {1'b0, big_exp != '0, big_frac, 3'b000};
      small_mant    = {1'b0, small_exp != '0, small_frac, 3'b000};
      exp_diff      = big_exp_eff - small_exp_eff;
      shift_amt     = (exp_diff > EXP_W'(SHMAX)) ? EXP_W'(SHMAX) : exp_diff;
      shift_wide    = {small_mant, {MW{1'b0}}} >> shift_amt;
      small_aligned = shift_wide[2*MW-1:MW] | {{(MW-1){1'b0}}, |shift_wide[MW-1:0]};
   end

   // A has the larger magnitude, so the difference never goes negative.
   always_comb begin
      add_sum = eff_sub_r ? (ma_r - mb_r) : (ma_r + mb_r);
   end

   fp_round_incr u_round (
      .lsb       (m_r[3]),
      .g         (m_r[2]),
      .r         (m_r[1]),
      .s         (m_r[0]),
      .sign      (sign_r),
      .rnd_mode  (rnd_r),
      .increment (rnd_incr),
      .inexact   (rnd_inexact)
   );

   // Rounding and packing.  A carry out of the increment leaves an all-zero
   // fraction with exponent+1.  A denormal that rounds up into the hidden bit
   // becomes the smallest normal naturally, because its exponent is already 1.
   // Overflow picks infinity or max-finite depending on the rounding direction.
   always_comb begin
      rnd_sum = {1'b0, m_r[MW-2:3]} + {{(FRAC_W+1){1'b0}}, rnd_incr};
      if (rnd_sum[FRAC_W+1]) begin
         fin_hidden = 1'b1;
         fin_frac   = rnd_sum[FRAC_W:1];
         fin_exp    = exp_r + EXP_ONE;
      end else begin
         fin_hidden = rnd_sum[FRAC_W];
         fin_frac   = rnd_sum[FRAC_W-1:0];
         fin_exp    = exp_r;
      end
      fin_ovf = fin_hidden && (fin_exp >= {1'b0, {EXP_W{1'b1}}});
      to_inf  = (rnd_r == RM_RNE) || ((rnd_r == RM_RUP) && !sign_r) ||
                ((rnd_r == RM_RDN) && sign_r);
      if (fin_ovf) begin
         rnd_result = to_inf ? {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                             : {sign_r, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
      end else begin
         rnd_result = {sign_r, fin_hidden ? fin_exp[EXP_W-1:0] : {EXP_W{1'b0}}, fin_frac};
      end
      rnd_flags                 = '0;
      rnd_flags[FLAG_OVERFLOW]  = fin_ovf;
      rnd_flags[FLAG_INEXACT]   = rnd_inexact | fin_ovf;
      rnd_flags[FLAG_UNDERFLOW] = !fin_hidden && rnd_inexact;
      rnd_flags[FLAG_ZERO]      = !fin_ovf && !fin_hidden && (fin_frac == '0);
   end

   // Sequencer.  Specials resolve in ALIGN and jump straight to DONE; normal
   // operands go ALIGN -> ADD -> NORM (one left shift per cycle) -> ROUND.
   // Result and flags are registered on entry to DONE and held until taken.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state       <= ST_IDLE;
         a_r         <= '0;
         b_r         <= '0;
         rnd_r       <= RM_RNE;
         ma_r        <= '0;
         mb_r        <= '0;
         m_r         <= '0;
         exp_r       <= '0;
         sign_r      <= 1'b0;
         eff_sub_r   <= 1'b0;
         result_r    <= '0;
         flags_r     <= '0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_r   <= opa;
                  b_r   <= opb ^ {op_sub, {(W-1){1'b0}}};
                  rnd_r <= rnd_mode;
                  state <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (a_nan || b_nan) begin
                  result_r               <= qnan_val;
                  flags_r                <= '0;
                  flags_r[FLAG_INVALID]  <= a_snan | b_snan;
                  out_valid_r            <= 1'b1;
                  state                  <= ST_DONE;
               end else if (a_inf && b_inf && (a_r[W-1] != b_r[W-1])) begin
                  result_r               <= qnan_val;
                  flags_r                <= '0;
                  flags_r[FLAG_INVALID]  <= 1'b1;
                  out_valid_r            <= 1'b1;
                  state                  <= ST_DONE;
               end else if (a_inf || b_inf) begin
                  result_r               <= a_inf ? a_r : b_r;
                  flags_r                <= '0;
                  out_valid_r            <= 1'b1;
                  state                  <= ST_DONE;
               end else if (a_zero && b_zero) begin
                  result_r               <= {zero_sign, {(W-1){1'b0}}};
                  flags_r                <= '0;
                  flags_r[FLAG_ZERO]     <= 1'b1;
                  out_valid_r            <= 1'b1;
                  state                  <= ST_DONE;
               end else begin
                  ma_r      <= big_mant;
                  mb_r      <= small_aligned;
                  exp_r     <= {1'b0, big_exp_eff};
                  sign_r    <= big_sign;
                  eff_sub_r <= a_r[W-1] ^ b_r[W-1];
                  state     <= ST_ADD;
               end
            end
            ST_ADD: begin
               m_r <= add_sum;
               if (add_sum == '0) begin
                  sign_r <= (rnd_r == RM_RDN);
               end
               state <= ST_NORM;
            end
            ST_NORM: begin
               if (m_r[MW-1]) begin
                  m_r   <= {1'b0, m_r[MW-1:2], m_r[1] | m_r[0]};
                  exp_r <= exp_r + EXP_ONE;
                  state <= ST_ROUND;
               end else if (!m_r[MW-2] && (m_r != '0) && (exp_r > EXP_ONE)) begin
                  m_r   <= m_r << 1;
                  exp_r <= exp_r - EXP_ONE;
               end else begin
                  state <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               result_r    <= rnd_result;
               flags_r     <= rnd_flags;
               out_valid_r <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_seq
// Directed vectors with hand-computed results for the single-precision
// configuration of fp_addsub_seq.  Flags are compared as the vector
// {invalid, overflow, underflow, inexact, zero}.
// ---------------------------------------------------------------------------
module tb_fp_addsub_seq;

   logic        clk_in, rst;
   logic        in_valid, in_ready;
   logic [31:0] opa, opb, result;
   logic        op_sub;
   logic [1:0]  rnd_mode;
   logic        out_valid, out_ready;
   logic        invalid, overflow, underflow, inexact, zero;

   int vectors_applied = 0;
   int miscompares     = 0;

   fp_addsub_seq #(.EXP_W(8), .FRAC_W(23)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opa       (opa),
      .opb       (opb),
      .op_sub    (op_sub),
      .rnd_mode  (rnd_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .invalid   (invalid),
      .overflow  (overflow),
      .underflow (underflow),
      .inexact   (inexact),
      .zero      (zero)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Last-resort guard in case a handshake never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors_applied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one operation, scramble the inputs right after capture, measure
   // latency from the accept edge, check result/flags, and optionally hold
   // out_ready low for three cycles before releasing the result.
   task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic [1:0] rm, input int lat,
                                input logic [31:0] res, input logic [4:0] flg,
                                input bit stall);
      int cycles;
      bit got;
      @(negedge clk_in);
      checkOutput({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);
      opa       = a;
      opb       = b;
      op_sub    = sub;
      rnd_mode  = rm;
      in_valid  = 1'b1;
      out_ready = !stall;
      @(posedge clk_in);
      #1;
      in_valid = 1'b0;
      opa      = $urandom;
      opb      = $urandom;
      op_sub   = ~sub;
      rnd_mode = ~rm;
      cycles   = 0;
      got      = 1'b0;
      while (!got && cycles < 64) begin
         @(posedge clk_in);
         cycles++;
         @(negedge clk_in);
         got = out_valid;
      end
      checkOutput({name, "/latency"}, 32'(cycles), 32'(lat));
      if (got) begin
         checkOutput({name, "/result"}, result, res);
         checkOutput({name, "/flags"}, 32'({invalid, overflow, underflow, inexact, zero}), 32'(flg));
         checkOutput({name, "/in_ready_busy"}, 32'(in_ready), 32'd0);
         if (stall) begin
            repeat (3) begin
               @(posedge clk_in);
               @(negedge clk_in);
               checkOutput({name, "/stall_valid"}, 32'(out_valid), 32'd1);
               checkOutput({name, "/stall_result"}, result, res);
               checkOutput({name, "/stall_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
         end
         @(posedge clk_in);
         @(negedge clk_in);
         checkOutput({name, "/valid_drop"}, 32'(out_valid), 32'd0);
         checkOutput({name, "/in_ready_back"}, 32'(in_ready), 32'd1);
      end
      out_ready = 1'b1;
   endtask

   // Directed sequence: reset state, normal arithmetic, specials, overflow,
   // rounding ties, denormals, cancellation with a stalled consumer, and a
   // reset that aborts an operation in the middle of normalisation.
   initial begin
      int rises;
      rst       = 1'b1;
      in_valid  = 1'b0;
      opa       = '0;
      opb       = '0;
      op_sub    = 1'b0;
      rnd_mode  = 2'b00;
      out_ready = 1'b1;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("reset/out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset/result", result, 32'h0);
      checkOutput("reset/flags", 32'({invalid, overflow, underflow, inexact, zero}), 32'd0);
      rst = 1'b0;
      @(negedge clk_in);
      checkOutput("reset/in_ready", 32'(in_ready), 32'd1);

      applyStimulus("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 4,  32'h40000000, 5'b00000, 1'b0);
      applyStimulus("near_cancel",   32'h3F800000, 32'h3F7FFFFF, 1'b1, 2'b00, 28, 32'h33800000, 5'b00000, 1'b0);
      applyStimulus("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 2'b00, 1,  32'h7FC00000, 5'b10000, 1'b0);
      applyStimulus("snan_in",       32'h7F800001, 32'h3F800000, 1'b0, 2'b00, 1,  32'h7FC00000, 5'b10000, 1'b0);
      applyStimulus("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 2'b00, 1,  32'h7F800000, 5'b00000, 1'b0);
      applyStimulus("ovf_rne",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 4,  32'h7F800000, 5'b01010, 1'b0);
      applyStimulus("ovf_rtz",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 4,  32'h7F7FFFFF, 5'b01010, 1'b0);
      applyStimulus("tie_rne",       32'h3F800000, 32'h33800000, 1'b0, 2'b00, 4,  32'h3F800000, 5'b00010, 1'b0);
      applyStimulus("tie_rup",       32'h3F800000, 32'h33800000, 1'b0, 2'b10, 4,  32'h3F800001, 5'b00010, 1'b0);
      applyStimulus("one_shift",     32'h3F800000, 32'hB3800000, 1'b0, 2'b00, 5,  32'h3F7FFFFF, 5'b00000, 1'b0);
      applyStimulus("denorm_add",    32'h00000001, 32'h00000001, 1'b0, 2'b00, 4,  32'h00000002, 5'b00000, 1'b0);
      applyStimulus("norm_to_denorm",32'h00800000, 32'h00000001, 1'b1, 2'b00, 4,  32'h007FFFFF, 5'b00000, 1'b0);
      applyStimulus("negzero_sum",   32'h80000000, 32'h80000000, 1'b0, 2'b00, 1,  32'h80000000, 5'b00001, 1'b0);
      applyStimulus("zero_minus_nz", 32'h00000000, 32'h80000000, 1'b0, 2'b00, 1,  32'h00000000, 5'b00001, 1'b0);
      applyStimulus("cancel_rdn",    32'h40400000, 32'h40400000, 1'b1, 2'b11, 4,  32'h80000000, 5'b00001, 1'b1);

      // Abort a long normalisation with reset; no result may appear
      @(negedge clk_in);
      opa      = 32'h3F800000;
      opb      = 32'h3F7FFFFF;
      op_sub   = 1'b1;
      rnd_mode = 2'b00;
      in_valid = 1'b1;
      @(posedge clk_in);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("abort/busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      rst = 1'b0;
      checkOutput("abort/in_ready", 32'(in_ready), 32'd1);
      checkOutput("abort/out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort/result", result, 32'h0);
      rises = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (out_valid) rises++;
      end
      checkOutput("abort/no_valid", 32'(rises), 32'd0);

      applyStimulus("after_abort",   32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 4,  32'h40000000, 5'b00000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
